// File: rtl/id_imm_ctrl_if.sv
// ID-stage immediate controller bus: IF/ID handshake, hazard/flush controls,
// the SEXT side-channel and the ID/EX register outputs.
interface id_imm_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_inst;
    logic [31:0]      id_pc;
    logic             hz_stall;
    logic             flush;
    logic [2:0]       sext_op;
    logic [24:0]      sext_din;
    logic [31:0]      sext_ext;
    logic             ex_ready;
    logic             ex_valid;
    logic [31:0]      ex_imm;
    logic [31:0]      ex_pc;
    logic             ex_imm_used;
    logic             ex_illegal;
    logic [CNT_W-1:0] bubble_cnt;

    // Controller side.
    modport slave (
        input  id_valid, id_inst, id_pc, hz_stall, flush, sext_ext, ex_ready,
        output id_ready, sext_op, sext_din, ex_valid, ex_imm, ex_pc,
        output ex_imm_used, ex_illegal, bubble_cnt
    );

    // Environment side (IF/ID, hazard unit, SEXT, EX).
    modport master (
        output id_valid, id_inst, id_pc, hz_stall, flush, sext_ext, ex_ready,
        input  id_ready, sext_op, sext_din, ex_valid, ex_imm, ex_pc,
        input  ex_imm_used, ex_illegal, bubble_cnt
    );
endinterface

// File: rtl/id_imm_ctrl.sv
// ID-stage immediate controller: decodes the SEXT op, captures the extended
// immediate and PC into the ID/EX register, and handles stall, flush with a
// wrong-path kill window, and bubble counting.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Upstream: id_valid/id_ready moves an instruction into ID/EX. Downstream:
// ex_valid/ex_ready hands the ID/EX register to EX. Neither ready depends on
// the same side's valid.
module id_imm_ctrl #(
    parameter int KILL_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    id_imm_ctrl_if.slave bus,
    output logic [0:0]  o_dbg_state,
    output logic [3:0]  o_dbg_kill_cnt
);
    localparam logic [0:0] ST_RUN       = 1'b0;
    localparam logic [0:0] ST_KILL      = 1'b1;
    localparam logic [3:0] KILL_LOAD    = 4'(KILL_CYCLES);
    localparam logic [0:0] FLUSH_TARGET = (KILL_CYCLES > 0) ? ST_KILL : ST_RUN;

    logic [0:0]       r_state;
    logic [3:0]       r_kill_cnt;
    logic             r_ex_valid;
    logic [31:0]      r_ex_imm;
    logic [31:0]      r_ex_pc;
    logic             r_ex_imm_used;
    logic             r_ex_illegal;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic [2:0]       w_sext_op;
    logic             w_imm_used;
    logic             w_illegal;
    logic             w_id_ready;
    logic             w_load;
    logic [2:0]       w_funct3;

    assign w_funct3 = bus.id_inst[14:12];

    // Opcode decode into SEXT op select and immediate/illegal flags.
    always_comb begin
        w_sext_op  = 3'b111;
        w_imm_used = 1'b0;
        w_illegal  = 1'b0;
        case (bus.id_inst[6:0])
            7'b0000011, 7'b1100111: begin w_sext_op = 3'b000; w_imm_used = 1'b1; end
            7'b0010011: begin
                w_sext_op  = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? 3'b001 : 3'b000;
                w_imm_used = 1'b1;
            end
            7'b0100011:             begin w_sext_op = 3'b010; w_imm_used = 1'b1; end
            7'b0110111, 7'b0010111: begin w_sext_op = 3'b011; w_imm_used = 1'b1; end
            7'b1100011:             begin w_sext_op = 3'b100; w_imm_used = 1'b1; end
            7'b1101111:             begin w_sext_op = 3'b101; w_imm_used = 1'b1; end
            7'b0110011:             begin w_sext_op = 3'b000; w_imm_used = 1'b0; end
            default:                begin w_sext_op = 3'b111; w_illegal  = 1'b1; end
        endcase
    end

    // KILL swallows wrong-path instructions unconditionally; RUN obeys stall
    // and downstream space. A flushed cycle never loads.
    assign w_id_ready = (r_state == ST_KILL) ? 1'b1
                      : (!bus.hz_stall && (!r_ex_valid || bus.ex_ready));
    assign w_load     = (r_state == ST_RUN) && bus.id_valid && w_id_ready && !bus.flush;

    // Kill-window FSM: flush (re)arms the window, each presented instruction consumes one slot.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state    <= ST_RUN;
            r_kill_cnt <= 4'd0;
        end else if (bus.flush) begin
            r_state    <= FLUSH_TARGET;
            r_kill_cnt <= KILL_LOAD;
        end else if (r_state == ST_KILL && bus.id_valid) begin
            r_kill_cnt <= r_kill_cnt - 4'd1;
            if (r_kill_cnt <= 4'd1) begin
                r_state <= ST_RUN;
            end
        end
    end

    // ID/EX register: flush > load > drain > hold; only the valid bit clears.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_imm      <= 32'h0;
            r_ex_pc       <= 32'h0;
            r_ex_imm_used <= 1'b0;
            r_ex_illegal  <= 1'b0;
        end else if (bus.flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_load) begin
            r_ex_valid    <= 1'b1;
            r_ex_imm      <= w_imm_used ? bus.sext_ext : 32'h0;
            r_ex_pc       <= bus.id_pc;
            r_ex_imm_used <= w_imm_used;
            r_ex_illegal  <= w_illegal;
        end else if (bus.ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    // Bubble counter: one tick per edge that sees an empty ID/EX register; wraps freely.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_bubble_cnt <= '0;
        end else if (!r_ex_valid) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bus.id_ready    = w_id_ready;
    assign bus.sext_op     = w_sext_op;
    assign bus.sext_din    = bus.id_inst[31:7];
    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_imm      = r_ex_imm;
    assign bus.ex_pc       = r_ex_pc;
    assign bus.ex_imm_used = r_ex_imm_used;
    assign bus.ex_illegal  = r_ex_illegal;
    assign bus.bubble_cnt  = r_bubble_cnt;
    assign o_dbg_state     = r_state;
    assign o_dbg_kill_cnt  = r_kill_cnt;
endmodule

// File: tb/tb_id_imm_ctrl.sv
// Bench for id_imm_ctrl: directed vectors, SEXT model, scoreboard + monitor.
module tb_id_imm_ctrl;
    logic       clk;
    logic       rst;
    logic [0:0] dbg_state;
    logic [3:0] dbg_kill_cnt;
    int         total;
    int         bad;

    // {imm[31:0], pc[31:0], imm_used, illegal}
    logic [65:0] exp_q[$];

    id_imm_ctrl_if #(.CNT_W(16)) bus ();

    id_imm_ctrl #(.KILL_CYCLES(1), .CNT_W(16)) dut (
        .cpu_clk        (clk),
        .cpu_rst        (rst),
        .bus            (bus),
        .o_dbg_state    (dbg_state),
        .o_dbg_kill_cnt (dbg_kill_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SEXT unit model (din = inst[31:7])
    always_comb begin
        logic [24:0] d;
        d = bus.sext_din;
        case (bus.sext_op)
            3'b000:  bus.sext_ext = {{20{d[24]}}, d[24:13]};
            3'b001:  bus.sext_ext = {27'b0, d[17:13]};
            3'b010:  bus.sext_ext = {{20{d[24]}}, d[24:18], d[4:0]};
            3'b011:  bus.sext_ext = {d[24:5], 12'b0};
            3'b100:  bus.sext_ext = {{19{d[24]}}, d[24], d[0], d[23:18], d[4:1], 1'b0};
            3'b101:  bus.sext_ext = {{11{d[24]}}, d[24], d[12:5], d[13], d[23:14], 1'b0};
            default: bus.sext_ext = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: an ID/EX entry is consumed at the edge following valid&&ready
    always @(negedge clk) begin
        logic [65:0] got;
        logic [65:0] want;
        if (!rst && bus.ex_valid && bus.ex_ready) begin
            got = {bus.ex_imm, bus.ex_pc, bus.ex_imm_used, bus.ex_illegal};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %h expected nothing", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL sb_entry: got %h expected %h", got, want);
                end
            end
        end
    end

    // driver tasks
    task automatic drive_id(input logic [31:0] inst, input logic [31:0] pc);
        bus.id_valid = 1'b1;
        bus.id_inst  = inst;
        bus.id_pc    = pc;
    endtask

    task automatic wait_accept(input logic [2:0] op, input logic [31:0] imm, input logic used,
                               input logic ill, input bit keep);
        bit done;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (i == 0) check("sext_op", 32'(bus.sext_op), 32'(op));
            if (bus.id_ready) begin
                if (keep) exp_q.push_back({imm, bus.id_pc, used, ill});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got id_ready=0 expected 1 within 50 cycles");
        end
        bus.id_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [2:0] op,
                        input logic [31:0] imm, input logic used, input logic ill, input bit keep);
        drive_id(inst, pc);
        wait_accept(op, imm, used, ill, keep);
    endtask

    task automatic idle(input int n);
        bus.id_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_inst  = 32'h0;
        bus.id_pc    = 32'h0;
        bus.hz_stall = 1'b0;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        // reset state
        check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_ex_imm", bus.ex_imm, 32'h0);
        check("rst_ex_pc", bus.ex_pc, 32'h0);
        check("rst_flags", {30'd0, bus.ex_imm_used, bus.ex_illegal}, 32'd0);
        check("rst_bubble", 32'(bus.bubble_cnt), 32'd0);
        check("rst_id_ready", 32'(bus.id_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'd0);

        @(posedge clk);
        #1 rst = 1'b0;
        bus.ex_ready = 1'b1;

        // addi with one-cycle latency
        send(32'hFFF00093, 32'h100, 3'b000, 32'hFFFFFFFF, 1'b1, 1'b0, 1);
        check("lat_ex_valid", 32'(bus.ex_valid), 32'd1);
        check("lat_ex_imm", bus.ex_imm, 32'hFFFFFFFF);
        check("lat_ex_pc", bus.ex_pc, 32'h100);
        // back-to-back stream, one per cycle
        send(32'h00309093, 32'h104, 3'b001, 32'h00000003, 1'b1, 1'b0, 1); // slli
        send(32'hFE112E23, 32'h108, 3'b010, 32'hFFFFFFFC, 1'b1, 1'b0, 1); // sw
        send(32'h12345037, 32'h10C, 3'b011, 32'h12345000, 1'b1, 1'b0, 1); // lui
        send(32'h00000463, 32'h110, 3'b100, 32'h00000008, 1'b1, 1'b0, 1); // beq +8
        send(32'h010000EF, 32'h114, 3'b101, 32'h00000010, 1'b1, 1'b0, 1); // jal +16
        send(32'h002081B3, 32'h118, 3'b000, 32'h00000000, 1'b0, 1'b0, 1); // add
        idle(2);

        // downstream backpressure
        bus.ex_ready = 1'b0;
        send(32'h80000093, 32'h200, 3'b000, 32'hFFFFF800, 1'b1, 1'b0, 1); // addi -2048
        drive_id(32'h4040D093, 32'h204);                                 // srai 4
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_id_ready", 32'(bus.id_ready), 32'd0);
            check("bp_ex_valid", 32'(bus.ex_valid), 32'd1);
            check("bp_ex_pc", bus.ex_pc, 32'h200);
            check("bp_ex_imm", bus.ex_imm, 32'hFFFFF800);
            @(posedge clk);
            #1;
        end
        bus.ex_ready = 1'b1;
        wait_accept(3'b001, 32'h00000004, 1'b1, 1'b0, 1);
        check("bp_new_pc", bus.ex_pc, 32'h204);
        idle(2);

        // hazard stall inserts one bubble, then illegal opcode
        send(32'h00001297, 32'h300, 3'b011, 32'h00001000, 1'b1, 1'b0, 1); // auipc
        bus.hz_stall = 1'b1;
        drive_id(32'h0000007F, 32'h304);
        @(negedge clk);
        check("hz_id_ready", 32'(bus.id_ready), 32'd0);
        check("hz_ex_valid", 32'(bus.ex_valid), 32'd1);
        @(posedge clk);
        #1 bus.hz_stall = 1'b0;
        check("hz_bubble", 32'(bus.ex_valid), 32'd0);
        check("hz_payload_hold", bus.ex_pc, 32'h300);
        wait_accept(3'b111, 32'h00000000, 1'b0, 1'b1, 1);
        check("ill_flag", 32'(bus.ex_illegal), 32'd1);
        check("ill_imm", bus.ex_imm, 32'h0);
        idle(2);

        // async reset in the middle of a kill window
        bus.ex_ready = 1'b0;
        send(32'hFF812283, 32'h400, 3'b000, 32'hFFFFFFF8, 1'b1, 1'b0, 0); // lw, flushed later
        check("kr_ex_imm", bus.ex_imm, 32'hFFFFFFF8);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("kr_state_kill", 32'(dbg_state), 32'd1);
        check("kr_kill_cnt", 32'(dbg_kill_cnt), 32'd1);
        check("kr_flush_valid", 32'(bus.ex_valid), 32'd0);
        check("kr_flush_hold", bus.ex_imm, 32'hFFFFFFF8);
        #2 rst = 1'b1;
        #1;
        check("kr_rst_imm", bus.ex_imm, 32'h0);
        check("kr_rst_pc", bus.ex_pc, 32'h0);
        check("kr_rst_state", 32'(dbg_state), 32'd0);
        check("kr_rst_kill_cnt", 32'(dbg_kill_cnt), 32'd0);
        check("kr_rst_id_ready", 32'(bus.id_ready), 32'd1);
        check("kr_rst_bubble", 32'(bus.bubble_cnt), 32'd0);

        // flush with kill window: first inst discarded, second loads
        @(posedge clk);
        #1 rst = 1'b0;
        bus.flush    = 1'b1;
        bus.ex_ready = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("fl_state_kill", 32'(dbg_state), 32'd1);
        check("fl_bubble1", 32'(bus.bubble_cnt), 32'd1);
        send(32'h00500113, 32'h500, 3'b000, 32'h00000005, 1'b1, 1'b0, 0);
        check("fl_state_run", 32'(dbg_state), 32'd0);
        check("fl_discard", 32'(bus.ex_valid), 32'd0);
        check("fl_bubble2", 32'(bus.bubble_cnt), 32'd2);
        send(32'h00700193, 32'h504, 3'b000, 32'h00000007, 1'b1, 1'b0, 1);
        check("fl_load", 32'(bus.ex_valid), 32'd1);
        check("fl_bubble3", 32'(bus.bubble_cnt), 32'd3);
        check("fl_pc", bus.ex_pc, 32'h504);
        idle(3);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
